// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the memory-access stage.
//   OP_LOAD / OP_STORE : major opcodes of loads and stores
//   F3_*               : funct3 width/sign encodings for loads and stores
//   ma_state_t         : memory-access FSM state
package rv32_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ma_state_t;

endpackage

// File: rtl/lsu_fmt.sv
// Load/store formatter (purely combinational).
//   opcode_i, funct3_i : decoded fields of the instruction in MA
//   off_i              : byte offset of the effective address (addr[1:0])
//   rd2_i              : store source value
//   rdata_i            : word returned by data memory
//   is_load_o/is_store_o : instruction class
//   misalign_o         : half with odd address or word not on a 4-byte boundary
//   be_o               : byte enables (shared by loads and stores)
//   wdata_o            : lane-replicated store data, 0 for loads
//   load_data_o        : extracted and extended load result, 0 for non-loads
module lsu_fmt
  import rv32_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rd2_i,
  input  logic [31:0] rdata_i,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [1:0]         size;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_sext;
  logic signed [31:0] half_sext;

  assign is_load_o  = (opcode_i == OP_LOAD);
  assign is_store_o = (opcode_i == OP_STORE);
  assign size       = funct3_i[1:0];

  always_comb begin
    misalign_o = 1'b0;
    if (is_load_o || is_store_o) begin
      unique case (size)
        2'b00:   misalign_o = 1'b0;
        2'b01:   misalign_o = off_i[0];
        default: misalign_o = |off_i;
      endcase
    end
  end

  always_comb begin
    unique case (size)
      2'b00:   be_o = 4'b0001 << off_i;
      2'b01:   be_o = 4'b0011 << off_i;
      default: be_o = 4'b1111;
    endcase
  end

  always_comb begin
    wdata_o = '0;
    if (is_store_o) begin
      unique case (size)
        2'b00:   wdata_o = {4{rd2_i[7:0]}};
        2'b01:   wdata_o = {2{rd2_i[15:0]}};
        default: wdata_o = rd2_i;
      endcase
    end
  end

  // Halves only ever sit at offset 0 or 2 once alignment is enforced,
  // so off_i[1] alone picks the lane.
  assign byte_sel  = rdata_i[{off_i, 3'b000} +: 8];
  assign half_sel  = rdata_i[{off_i[1], 4'b0000} +: 16];
  assign byte_s    = byte_sel;
  assign half_s    = half_sel;
  assign byte_sext = byte_s;
  assign half_sext = half_s;

  always_comb begin
    load_data_o = '0;
    if (is_load_o) begin
      unique case (funct3_i)
        F3_B:    load_data_o = byte_sext;
        F3_BU:   load_data_o = {24'b0, byte_sel};
        F3_H:    load_data_o = half_sext;
        F3_HU:   load_data_o = {16'b0, half_sel};
        default: load_data_o = rdata_i;
      endcase
    end
  end

endmodule

// File: rtl/ma_stage.sv
// Memory-access stage of the 5-stage RV32I pipeline.
// Issues loads/stores to data memory over a req/ready handshake, formats
// load/store data via lsu_fmt, stalls upstream while an access is
// outstanding, aborts an access that waits too long, and registers the
// result into the MA/WB boundary.
//   clk, rst_n                          : clock, asynchronous active-low reset
//   PC_M, ALU_Result_M, RD2_M, Instr_M  : EX/MA pipeline inputs
//   dmem_req/we/addr/be/wdata           : data memory request
//   dmem_rdata, dmem_ready              : data memory response
//   stall_M                             : freeze upstream pipeline registers
//   misalign_M                          : current load/store is misaligned
//   PC_W, ALU_Result_W, Read_Data_W,
//   Instr_W, bus_err_W                  : registered MA/WB boundary
module ma_stage
  import rv32_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_M,
  input  logic [31:0] ALU_Result_M,
  input  logic [31:0] RD2_M,
  input  logic [31:0] Instr_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_M,
  output logic        misalign_M,
  output logic [31:0] PC_W,
  output logic [31:0] ALU_Result_W,
  output logic [31:0] Read_Data_W,
  output logic [31:0] Instr_W,
  output logic        bus_err_W
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ma_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        is_load, is_store, misalign, mem_op, mem_go;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;
  logic        req_c, stall_c, complete, abort, retire, timeout;

  logic [31:0] pc_w_d, alu_w_d, rd_w_d, instr_w_d;
  logic        berr_w_d;

  lsu_fmt u_fmt (
    .opcode_i    (Instr_M[6:0]),
    .funct3_i    (Instr_M[14:12]),
    .off_i       (ALU_Result_M[1:0]),
    .rd2_i       (RD2_M),
    .rdata_i     (dmem_rdata),
    .is_load_o   (is_load),
    .is_store_o  (is_store),
    .misalign_o  (misalign),
    .be_o        (be),
    .wdata_o     (wdata),
    .load_data_o (load_data)
  );

  assign mem_op = is_load | is_store;
  assign mem_go = mem_op & ~misalign;

  // The counter starts at 0 on entry to WAIT, so an access gets
  // WAIT_LIMIT+1 request cycles in total before it is abandoned.
  assign timeout = (state_q == WAIT) && (cnt_q >= LIMIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mem_go && !dmem_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (timeout || dmem_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. In the abort cycle the request is already withdrawn,
  // so a late dmem_ready there is not treated as a completion.
  always_comb begin
    req_c    = 1'b0;
    stall_c  = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_go) begin
          req_c    = 1'b1;
          complete = dmem_ready;
          stall_c  = ~dmem_ready;
        end
      end
      WAIT: begin
        if (timeout) begin
          abort = 1'b1;
        end else begin
          req_c    = 1'b1;
          complete = dmem_ready;
          stall_c  = ~dmem_ready;
        end
      end
      default: ;
    endcase
  end

  // Upstream may still present a memory op while reset is held; keep the
  // bus and the pipeline quiet regardless.
  assign dmem_req   = req_c & rst_n;
  assign stall_M    = stall_c & rst_n;
  assign dmem_we    = is_store;
  assign dmem_addr  = {ALU_Result_M[31:2], 2'b00};
  assign dmem_be    = be;
  assign dmem_wdata = wdata;
  assign misalign_M = misalign;

  // Anything that neither retires nor aborts (stall, misaligned op) turns
  // into a bubble so WB never sees a duplicate.
  assign retire = complete | abort | ((state_q == IDLE) & ~mem_op);

  always_comb begin
    pc_w_d    = '0;
    alu_w_d   = '0;
    rd_w_d    = '0;
    instr_w_d = '0;
    berr_w_d  = abort;
    if (retire) begin
      pc_w_d    = PC_M;
      alu_w_d   = ALU_Result_M;
      instr_w_d = Instr_M;
      rd_w_d    = (complete && is_load) ? load_data : '0;
    end
  end

  // MA/WB boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC_W         <= '0;
      ALU_Result_W <= '0;
      Read_Data_W  <= '0;
      Instr_W      <= '0;
      bus_err_W    <= 1'b0;
    end else begin
      PC_W         <= pc_w_d;
      ALU_Result_W <= alu_w_d;
      Read_Data_W  <= rd_w_d;
      Instr_W      <= instr_w_d;
      bus_err_W    <= berr_w_d;
    end
  end

endmodule

// File: tb/tb_ma_stage.sv
`timescale 1ns/1ps
module tb_ma_stage;
  import rv32_pkg::*;

  localparam int WL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PC_M, ALU_Result_M, RD2_M, Instr_M, dmem_rdata;
  logic        dmem_ready;
  logic        dmem_req, dmem_we, stall_M, misalign_M, bus_err_W;
  logic [31:0] dmem_addr, dmem_wdata, PC_W, ALU_Result_W, Read_Data_W, Instr_W;
  logic [3:0]  dmem_be;

  ma_stage #(.WAIT_LIMIT(WL), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .PC_M(PC_M), .ALU_Result_M(ALU_Result_M), .RD2_M(RD2_M), .Instr_M(Instr_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_M(stall_M), .misalign_M(misalign_M),
    .PC_W(PC_W), .ALU_Result_W(ALU_Result_W), .Read_Data_W(Read_Data_W),
    .Instr_W(Instr_W), .bus_err_W(bus_err_W)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req, we, stall, mis;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] pc_w, alu_w, rd_w, instr_w;
    logic        berr_w;
  } exp_t;

  exp_t exp_q[$];
  exp_t prev;
  bit   have_prev = 0;
  bit   chk_en = 0;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] ldf3 [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
  logic [2:0] stf3 [3] = '{F3_B, F3_H, F3_W};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_misalign(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int n, m;
    n = nbytes(f3);
    if (n == 4) return 4'hF;
    m = ((1 << n) - 1) << addr[1:0];
    return 4'(m);
  endfunction

  // Byte lane i of the bus carries byte (i mod size) of the source.
  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rd2);
    logic [31:0] r;
    int n;
    n = nbytes(f3);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = rd2[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    longint unsigned v, mask;
    int n;
    n    = nbytes(f3);
    v    = longint'(rdata) >> (8 * int'(addr[1:0]));
    mask = (64'd1 << (8 * n)) - 1;
    v    = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e.req = 0; e.we = 0; e.stall = 0; e.mis = 0;
    e.addr = '0; e.wdata = '0; e.be = '0;
    e.pc_w = '0; e.alu_w = '0; e.rd_w = '0; e.instr_w = '0; e.berr_w = 0;
    return e;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    return {r[31:15], f3, r[11:7], op};
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] instr, pc, alu, rd2, input logic rdy,
                       input logic [31:0] rdata, input exp_t e);
    @(posedge clk); #1;
    Instr_M = instr; PC_M = pc; ALU_Result_M = alu; RD2_M = rd2;
    dmem_ready = rdy; dmem_rdata = rdata;
    exp_q.push_back(e);
  endtask

  // delay = number of request cycles without ready before ready is given;
  // anything above WL means the memory never answers.
  task automatic run_instr(input logic [31:0] instr, pc, addr, rd2, rdata, input int delay);
    logic [2:0] f3;
    logic       ld, st, mis;
    exp_t       base, e;
    int         nst;
    f3  = instr[14:12];
    ld  = (instr[6:0] == OP_LOAD);
    st  = (instr[6:0] == OP_STORE);
    mis = (ld || st) && model_misalign(f3, addr);
    base       = blank();
    base.we    = st;
    base.addr  = {addr[31:2], 2'b00};
    base.be    = model_be(f3, addr);
    base.wdata = st ? model_wdata(f3, rd2) : 32'h0;
    base.mis   = mis;
    if (!(ld || st) || mis) begin
      e = base;
      if (!mis) begin
        e.pc_w = pc; e.alu_w = addr; e.instr_w = instr;
      end
      drive(instr, pc, addr, rd2, 1'($urandom_range(0, 1)), $urandom, e);
    end else begin
      nst = (delay > WL) ? WL + 1 : delay;
      for (int c = 0; c < nst; c++) begin
        e = base; e.req = 1; e.stall = 1;
        drive(instr, pc, addr, rd2, 1'b0, $urandom, e);
      end
      e = base;
      e.pc_w = pc; e.alu_w = addr; e.instr_w = instr;
      if (delay > WL) begin
        e.berr_w = 1;
        drive(instr, pc, addr, rd2, 1'($urandom_range(0, 1)), $urandom, e);
      end else begin
        e.req  = 1;
        e.rd_w = ld ? model_load(f3, addr, rdata) : 32'h0;
        drive(instr, pc, addr, rd2, 1'b1, rdata, e);
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t r;
    if (chk_en && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("dmem_req", 32'(dmem_req), 32'(r.req));
      chk("stall_M", 32'(stall_M), 32'(r.stall));
      chk("misalign_M", 32'(misalign_M), 32'(r.mis));
      if (r.req) begin
        chk("dmem_we", 32'(dmem_we), 32'(r.we));
        chk("dmem_addr", dmem_addr, r.addr);
        chk("dmem_be", 32'(dmem_be), 32'(r.be));
        chk("dmem_wdata", dmem_wdata, r.wdata);
      end
      if (have_prev) begin
        chk("PC_W", PC_W, prev.pc_w);
        chk("ALU_Result_W", ALU_Result_W, prev.alu_w);
        chk("Read_Data_W", Read_Data_W, prev.rd_w);
        chk("Instr_W", Instr_W, prev.instr_w);
        chk("bus_err_W", 32'(bus_err_W), 32'(prev.berr_w));
      end
      prev = r;
      have_prev = 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] LW_I  = 32'h0000_2283;  // lw  x5
  localparam logic [31:0] LB_I  = 32'h0000_0283;
  localparam logic [31:0] LBU_I = 32'h0000_4283;
  localparam logic [31:0] LH_I  = 32'h0000_1283;
  localparam logic [31:0] LHU_I = 32'h0000_5283;
  localparam logic [31:0] SB_I  = 32'h0050_0023;
  localparam logic [31:0] SH_I  = 32'h0050_1023;
  localparam logic [31:0] SW_I  = 32'h0050_2023;
  localparam logic [31:0] ADD_I = 32'h0020_82B3;

  initial begin
    Instr_M = LW_I; PC_M = 32'h40; ALU_Result_M = 32'h100; RD2_M = '0;
    dmem_rdata = '0; dmem_ready = 1'b0;

    // Model pins against hand-computed values.
    chk("pin_lb",    model_load(F3_B,  32'h103, 32'h80FF_0000), 32'hFFFF_FF80);
    chk("pin_lbu",   model_load(F3_BU, 32'h103, 32'h80FF_0000), 32'h0000_0080);
    chk("pin_lh",    model_load(F3_H,  32'h102, 32'h80FF_0000), 32'hFFFF_80FF);
    chk("pin_sb_be", 32'(model_be(F3_B, 32'h201)), 32'h2);
    chk("pin_sb_wd", model_wdata(F3_B, 32'h1234_5678), 32'h7878_7878);
    chk("pin_sh_be", 32'(model_be(F3_H, 32'h202)), 32'hC);
    chk("pin_mis",   32'(model_misalign(F3_W, 32'h102)), 32'h1);

    // Reset state, with a load presented during reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_stall", 32'(stall_M), 32'h0);
    chk("rst_PC_W", PC_W, 32'h0);
    chk("rst_Instr_W", Instr_W, 32'h0);
    chk("rst_bus_err", 32'(bus_err_W), 32'h0);
    Instr_M = '0;
    @(negedge clk);
    rst_n = 1'b1;
    have_prev = 0;
    chk_en = 1;

    // Directed cases.
    run_instr(LW_I,  32'h1000, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    run_instr(LB_I,  32'h1004, 32'h103, 32'h0, 32'h80FF_0000, 1);
    run_instr(LBU_I, 32'h1008, 32'h103, 32'h0, 32'h80FF_0000, 0);
    run_instr(LH_I,  32'h100C, 32'h102, 32'h0, 32'h80FF_0000, 0);
    run_instr(LHU_I, 32'h1010, 32'h102, 32'h0, 32'h80FF_0000, 2);
    run_instr(SB_I,  32'h1014, 32'h201, 32'h1234_5678, 32'h0, 0);
    run_instr(SH_I,  32'h1018, 32'h202, 32'hCAFE_F00D, 32'h0, 1);
    run_instr(SW_I,  32'h101C, 32'h204, 32'hA5A5_5A5A, 32'h0, 3);
    run_instr(LW_I,  32'h1020, 32'h102, 32'h0, 32'h1111_1111, 0);
    run_instr(LH_I,  32'h1024, 32'h101, 32'h0, 32'h1111_1111, 0);
    run_instr(ADD_I, 32'h1028, 32'h0000_0777, 32'h5, 32'h0, 0);
    run_instr(LW_I,  32'h102C, 32'h300, 32'h0, 32'h2222_2222, WL + 3);
    run_instr(SW_I,  32'h1030, 32'h304, 32'h3333_3333, 32'h0, WL);
    run_instr(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int          kind, dly, n;
      logic [2:0]  f3;
      logic [31:0] ins, a, pc;
      kind = $urandom_range(0, 9);
      pc   = $urandom;
      f3   = 3'($urandom);
      if (kind < 3) begin
        case ($urandom_range(0, 3))
          0:       ins = 32'h0;
          1:       ins = mk(7'b0110011, f3);
          2:       ins = mk(7'b0010011, f3);
          default: ins = mk(7'b0110111, f3);
        endcase
      end else if (kind < 7) begin
        f3  = ldf3[$urandom_range(0, 4)];
        ins = mk(OP_LOAD, f3);
      end else begin
        f3  = stf3[$urandom_range(0, 2)];
        ins = mk(OP_STORE, f3);
      end
      n = 1 << f3[1:0];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      case ($urandom_range(0, 9))
        0, 1, 2, 3:    dly = 0;
        4, 5, 6, 7, 8: dly = $urandom_range(1, WL);
        default:       dly = $urandom_range(WL + 1, WL + 3);
      endcase
      if (ins == 32'h0) begin
        pc = '0; a = '0;
      end
      run_instr(ins, pc, a, $urandom, $urandom, dly);
    end
    run_instr(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk_en = 0;
    exp_q.delete();

    // Reset in the middle of WAIT.
    @(posedge clk); #1;
    Instr_M = LW_I; PC_M = 32'h2000; ALU_Result_M = 32'h400; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midwait_req_pre", 32'(dmem_req), 32'h1);
    chk("midwait_stall_pre", 32'(stall_M), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midwait_req", 32'(dmem_req), 32'h0);
    chk("midwait_stall", 32'(stall_M), 32'h0);
    chk("midwait_Instr_W", Instr_W, 32'h0);
    chk("midwait_Read_W", Read_Data_W, 32'h0);
    Instr_M = '0;
    @(negedge clk);
    rst_n = 1'b1;
    have_prev = 0;
    chk_en = 1;
    run_instr(ADD_I, 32'h2004, 32'h55, 32'h0, 32'h0, 0);
    run_instr(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk_en = 0;
    exp_q.delete();

    // Reset clears a retired result immediately.
    @(posedge clk); #1;
    Instr_M = ADD_I; PC_M = 32'h3000; ALU_Result_M = 32'h99;
    @(posedge clk); #1;
    chk("pre_rst_PC_W", PC_W, 32'h3000);
    rst_n = 1'b0;
    #1;
    chk("async_rst_PC_W", PC_W, 32'h0);
    chk("async_rst_ALU_W", ALU_Result_W, 32'h0);
    chk("async_rst_Instr_W", Instr_W, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
